// File: rtl/btn_debounce.sv
// btn_debounce: synchroniser, bounce filter and edge detector for the front-panel buttons
// (UP, DN, BACK, OK, INTERRUPT, D0..D2 expansion lines).
//
// Every raw pad passes through a 2-flop synchroniser. Its level is then filtered on a shared
// sample tick. A level change is accepted only after STABLE_CNT consecutive samples that differ
// from the current debounced level. Any sample that matches the current level restarts the count.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   btn_raw      unsynchronised pad levels
//   evt_clr      per-channel clear strobe for evt_pending
//   btn_state    debounced level, 1 = pressed (polarity-normalised)
//   btn_press    one-clk pulse on an accepted press
//   btn_release  one-clk pulse on an accepted release
//   evt_pending  sticky "pressed since last clear" flag; a set and a clear in the same clk
//                leave the flag set
//   tick         one-clk sample strobe, shared with other blocks
//
// Optional build: define BTN_DEBOUNCE_AUTOREPEAT_EN to give each channel a hold counter.
// While a button is held, it issues extra btn_press pulses: the first one REPEAT_DELAY ticks
// after the accepted press, then one every REPEAT_RATE ticks.
module btn_debounce #(
  parameter int unsigned CHANNELS     = 6,
  parameter int unsigned CLK_DIV      = 16000,
  parameter int unsigned STABLE_CNT   = 8,
  parameter string       ACTIVE_LOW   = "TRUE",
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_raw,
  input  logic [CHANNELS-1:0] evt_clr,
  output logic [CHANNELS-1:0] btn_state,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] evt_pending,
  output logic                tick
);

  localparam int unsigned PresW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntW  = $clog2(STABLE_CNT + 1);
  localparam bit          ActLow = (ACTIVE_LOW == "TRUE");
  localparam logic [PresW-1:0] PresLast = PresW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(STABLE_CNT - 1);
  localparam logic [CHANNELS-1:0] IdleLvl = {CHANNELS{ActLow}};

  // Elaboration-time parameter range checks.
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("btn_debounce: CHANNELS must be 1..16");
  end
  if (STABLE_CNT < 1 || STABLE_CNT > 255) begin : g_bad_stable
    $error("btn_debounce: STABLE_CNT must be 1..255");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("btn_debounce: CLK_DIV must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("btn_debounce: REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  logic [PresW-1:0]    presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [CHANNELS-1:0] s1_q, s2_q;
  logic [CHANNELS-1:0] state_q, state_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CntW-1:0]     cnt_q [CHANNELS];
  logic [CntW-1:0]     cnt_d [CHANNELS];
  logic [CHANNELS-1:0] lvl;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);
  localparam logic [HoldW-1:0] DelayLast = HoldW'(REPEAT_DELAY - 1);
  localparam logic [HoldW-1:0] RateLast  = HoldW'(REPEAT_RATE - 1);

  logic [HoldW-1:0]    hold_q [CHANNELS];
  logic [HoldW-1:0]    hold_d [CHANNELS];
  // first_q: the next repeat uses REPEAT_DELAY rather than REPEAT_RATE.
  logic [CHANNELS-1:0] first_q, first_d;
`endif

  // Prescaler. tick is registered so that it is high during the clk in which presc_q holds
  // CLK_DIV-1. The filter therefore samples on the edge that wraps the prescaler.
  always_comb begin
    presc_d = (presc_q == PresLast) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_d == PresLast);
  end

  always_comb begin
    lvl       = s2_q ^ IdleLvl;
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    hold_d    = hold_q;
    first_d   = first_q;
`endif
    if (tick_q) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (lvl[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          state_d[i]   = lvl[i];
          cnt_d[i]     = '0;
          press_d[i]   = lvl[i];
          release_d[i] = ~lvl[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        if (state_d[i] != state_q[i]) begin
          // Any accepted edge restarts the hold timing; on a release it stays idle.
          hold_d[i]  = '0;
          first_d[i] = 1'b1;
        end else if (state_q[i]) begin
          if (hold_q[i] == (first_q[i] ? DelayLast : RateLast)) begin
            press_d[i] = 1'b1;
            hold_d[i]  = '0;
            first_d[i] = 1'b0;
          end else begin
            hold_d[i] = hold_q[i] + 1'b1;
          end
        end
`endif
      end
    end
    pend_d = (pend_q & ~evt_clr) | press_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      s1_q      <= IdleLvl;
      s2_q      <= IdleLvl;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      pend_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      first_q <= first_d;
      hold_q  <= hold_d;
    end
  end
`endif

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign evt_pending = pend_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: CLK_DIV=4, STABLE_CNT=3, active-low pads.
// Timing notes:
//   - Inputs are driven and outputs sampled on the falling clock edge.
//   - The filter samples on rising edges where tick is high.
//   - A pad change made just after such an edge (T) reaches s2 at T+2.
//   - The change is then counted at T+4 and T+8, and accepted at T+12.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] btn_raw;
  logic [5:0] evt_clr;
  logic [5:0] btn_state, btn_press, btn_release, evt_pending;
  logic       tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_debounce #(
    .CHANNELS  (6),
    .CLK_DIV   (4),
    .STABLE_CNT(3),
    .ACTIVE_LOW("TRUE")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .evt_clr    (evt_clr),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .evt_pending(evt_pending),
    .tick       (tick)
  );

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  logic [5:0] ar_raw;
  logic [5:0] ar_clr;
  logic [5:0] ar_state, ar_press, ar_release, ar_pend;
  logic       ar_tick;

  btn_debounce #(
    .CHANNELS    (6),
    .CLK_DIV     (4),
    .STABLE_CNT  (3),
    .ACTIVE_LOW  ("TRUE"),
    .REPEAT_DELAY(5),
    .REPEAT_RATE (2)
  ) dut_ar (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (ar_raw),
    .evt_clr    (ar_clr),
    .btn_state  (ar_state),
    .btn_press  (ar_press),
    .btn_release(ar_release),
    .evt_pending(ar_pend),
    .tick       (ar_tick)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on the falling edge just after a filter-sampling rising edge.
  task automatic sync_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("tick_found", {31'd0, tick}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    btn_raw = 6'b111111;
    evt_clr = 6'b000000;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    ar_raw = 6'b111111;
    ar_clr = 6'b000000;
`endif
    wait_n(2);
    chk("rst_state",   btn_state,   0);
    chk("rst_press",   btn_press,   0);
    chk("rst_release", btn_release, 0);
    chk("rst_pend",    evt_pending, 0);
    chk("rst_tick",    tick,        0);

    // Release reset; tick is high after rising edges 3, 7, 11, ...
    rst = 1'b1;
    for (int k = 1; k <= 207; k++) begin
      @(negedge clk);
      chk("tick_cadence", tick, (k % 4 == 3) ? 1 : 0);
      chk("idle_outputs", {btn_state, btn_press, btn_release, evt_pending}, 0);
    end

    // Channel 0 press.
    sync_tick();
    btn_raw[0] = 1'b0;
    wait_n(11);
    chk("c0_state_early", btn_state, 6'b000000);
    chk("c0_press_early", btn_press, 6'b000000);
    wait_n(1);
    chk("c0_state", btn_state,   6'b000001);
    chk("c0_press", btn_press,   6'b000001);
    chk("c0_pend",  evt_pending, 6'b000001);
    wait_n(1);
    chk("c0_press_end", btn_press, 6'b000000);
    chk("c0_state_hold", btn_state, 6'b000001);

    // Channel 1 bounce: 5-clk phases never span three samples.
    for (int p = 0; p < 20; p++) begin
      btn_raw[1] = (p % 2 == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk("c1_bounce", {btn_state[1], btn_press[1]}, 2'b00);
      end
    end
    sync_tick();
    btn_raw[1] = 1'b0;
    wait_n(11);
    chk("c1_press_early", btn_press, 6'b000000);
    wait_n(1);
    chk("c1_press", btn_press,   6'b000010);
    chk("c1_state", btn_state,   6'b000011);
    chk("c1_pend",  evt_pending, 6'b000011);
    wait_n(1);
    chk("c1_press_end", btn_press, 6'b000000);

    // Channel 0 release; pending stays set.
    sync_tick();
    btn_raw[0] = 1'b1;
    wait_n(11);
    chk("c0_rel_early", btn_release, 6'b000000);
    wait_n(1);
    chk("c0_release",   btn_release, 6'b000001);
    chk("c0_rel_state", btn_state,   6'b000010);
    chk("c0_rel_pend",  evt_pending, 6'b000011);
    wait_n(1);
    chk("c0_rel_end", btn_release, 6'b000000);

    // Channel 0 re-press with a clear on the same edge: the set takes precedence.
    sync_tick();
    btn_raw[0] = 1'b0;
    wait_n(11);
    evt_clr = 6'b000001;
    wait_n(1);
    evt_clr = 6'b000000;
    chk("clr_vs_set_press", btn_press,   6'b000001);
    chk("clr_vs_set_pend",  evt_pending, 6'b000011);
    // Plain clear of channel 0, plus a clear of channel 5, which has nothing pending.
    evt_clr = 6'b100001;
    wait_n(1);
    evt_clr = 6'b000000;
    chk("clr_pend", evt_pending, 6'b000010);

    // Reset while channel 2 has counted two samples.
    sync_tick();
    btn_raw[2] = 1'b0;
    wait_n(8);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_state", btn_state,   0);
    chk("async_rst_pend",  evt_pending, 0);
    chk("async_rst_press", btn_press,   0);
    chk("async_rst_tick",  tick,        0);
    @(negedge clk);
    rst = 1'b1;
    // Channels 0..2 are still held low, so all three are accepted together after a full count.
    wait_n(11);
    chk("post_rst_early", btn_state, 6'b000000);
    chk("post_rst_nopls", btn_press, 6'b000000);
    wait_n(1);
    chk("post_rst_press", btn_press,   6'b000111);
    chk("post_rst_state", btn_state,   6'b000111);
    chk("post_rst_pend",  evt_pending, 6'b000111);
    wait_n(1);
    chk("post_rst_pend_end", btn_press, 6'b000000);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    // Channel 3 hold with auto-repeat.
    // Press is accepted at +12. Repeats follow 5 ticks later (+32), then every 2 ticks.
    // The pad is released after +49. The button still reads pressed through +56, so one more
    // repeat fires then. The release is accepted at +60.
    sync_tick();
    ar_raw[3] = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      chk("ar_press", ar_press[3],
          (k == 12 || k == 32 || k == 40 || k == 48 || k == 56) ? 1 : 0);
      chk("ar_release", ar_release[3], (k == 60) ? 1 : 0);
      if (k == 49) ar_raw[3] = 1'b1;
    end
    chk("ar_pend", ar_pend, 6'b001000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Debounce and edge-detect block for the front-panel buttons (UP, DN, BACK, OK, INTERRUPT and the D0..D2 expansion lines).
- Sits directly upstream of the core's button inputs and the port-A PIO input pins, replacing the bare input flops.
- Synchronises each raw pad, filters bounce with a shared millisecond tick, and produces clean levels, one-cycle press/release pulses and sticky press flags.

Parameters:
- CHANNELS, 6: number of independent button channels (1..16).
- CLK_DIV, 16000: sys clocks per sample tick (1 ms at 16 MHz).
- STABLE_CNT, 8: consecutive differing samples required before a level change is accepted (1..255).
- ACTIVE_LOW, "TRUE": "TRUE" means a pad reads 0 when pressed; "FALSE" means it reads 1 when pressed.
- REPEAT_DELAY, 500: ticks a button must be held before the first auto-repeat. Used only with the optional feature.
- REPEAT_RATE, 100: ticks between subsequent auto-repeats. Used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- btn_raw  input  CHANNELS  unsynchronised pad levels.
- evt_clr  input  CHANNELS  per-channel clear strobe for evt_pending, one clk wide.
- btn_state  output  CHANNELS  debounced level, 1 = pressed, polarity-normalised.
- btn_press  output  CHANNELS  one-clk pulse on an accepted press.
- btn_release  output  CHANNELS  one-clk pulse on an accepted release.
- evt_pending  output  CHANNELS  sticky "pressed since last clear" flag.
- tick  output  1  one-clk sample strobe, exported for reuse by rtc/other blocks.

Behaviour:
- Reset (rst low, asynchronous):
  - prescaler = 0, all debounce counters = 0, tick = 0.
  - sync flops = idle pad level (1 if ACTIVE_LOW="TRUE", else 0).
  - btn_state, btn_press, btn_release, evt_pending = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick is a registered output, high for exactly the one clk in which the prescaler holds CLK_DIV-1.
- Synchroniser: 2-flop per channel. Debounce logic sees only the second flop (s2), so input latency is 2 clks.
- Per-channel filter, evaluated only on tick clocks:
  - lvl = s2 XOR (ACTIVE_LOW=="TRUE").
  - If lvl == btn_state: counter <= 0 (any bounce restarts the count).
  - If lvl != btn_state and counter == STABLE_CNT-1: btn_state <= lvl, counter <= 0, and pulse btn_press (lvl=1) or btn_release (lvl=0).
  - Otherwise counter <= counter+1.
  - Counter width is clog2(STABLE_CNT+1). The counter never exceeds STABLE_CNT-1.
- Pulse timing: press/release pulses are registered in the same edge that updates btn_state. They are high exactly one clk, then 0.
- Worst-case latency from a clean pad edge to btn_state change: 2 clks + STABLE_CNT*CLK_DIV clks.
- evt_pending:
  - Set by btn_press.
  - Cleared by evt_clr.
  - If set and clear occur in the same clk, set wins.
  - A clear on a channel with no pending flag has no effect.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.
- STABLE_CNT=1: the level is accepted on the first tick that differs.
- Reset mid-count discards partial counts; no pulse is emitted by reset.
- Outputs are purely registered. No combinational path from btn_raw or evt_clr to any output.

Optional Feature:
- Macro BTN_DEBOUNCE_AUTOREPEAT_EN.
- When defined, each channel gets a hold counter (width clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)):
  - Cleared on the press pulse.
  - Incremented on each tick while btn_state=1.
  - On reaching REPEAT_DELAY-1 (first repeat) or REPEAT_RATE-1 (subsequent repeats), it emits an extra btn_press pulse, sets evt_pending, and reloads to 0.
  - Release clears it and stops repeats. btn_release is unaffected.
- When undefined: no hold counters are synthesised; exactly one btn_press per accepted press. REPEAT_* parameters are ignored.

Test Plan:
- Bench uses CLK_DIV=4, STABLE_CNT=3, ACTIVE_LOW="TRUE".
- Reset release with all btn_raw=1 -> tick first high at clk 4 (counting from the first edge after reset), then every 4 clks; all outputs 0 for 200 clks.
- btn_raw[0] driven 0 and held -> btn_state[0]=1 and btn_press[0] high for one clk on the 3rd tick after s2 goes 0; evt_pending[0]=1.
- btn_raw[1] toggling 0/1 every 5 clks for 100 clks, then held 0 -> no pulse during bounce; single btn_press[1] exactly 3 ticks after the final stable edge.
- Release channel 0 (btn_raw[0]=1) -> btn_release[0] one clk after 3 ticks; evt_pending[0] stays 1 until evt_clr[0]; evt_clr pulsed in the same clk as a new btn_press -> evt_pending stays 1.
- Drive rst low while channel 2 counter=2 -> all outputs 0 immediately (asynchronously); after release a fresh 3 ticks is needed to accept the press.
- With BTN_DEBOUNCE_AUTOREPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, hold channel 3 -> press pulses at accept, +5 ticks, then every 2 ticks; stop on release.
